// File: rtl/conv_encoder_if.sv
// conv_encoder_if: start/ready request, symbol stream and code-word result of the convolutional encoder.
interface conv_encoder_if #(
    parameter int r      = 2,
    parameter int lenin  = 10,
    parameter int lenout = 5
);
    logic              start;
    logic [lenout-1:0] msg_in;
    logic              ready;
    logic [r-1:0]      sym_out;
    logic              sym_valid;
    logic [lenin-1:0]  codeout;
    logic              done;

    modport master (
        output start, msg_in,
        input  ready, sym_out, sym_valid, codeout, done
    );

    modport slave (
        input  start, msg_in,
        output ready, sym_out, sym_valid, codeout, done
    );
endinterface

// File: rtl/conv_encoder.sv
// conv_encoder: truncated rate-1/r, constraint-length-K feed-forward convolutional encoder,
// one message bit per clock MSB first, parallel code word framed for the viterbi decoder.
module conv_encoder #(
    parameter int               r      = 2,
    parameter int               K      = 3,
    parameter int               lenin  = 10,
    parameter int               lenout = 5,
    parameter logic [r*K-1:0]   G      = 6'b111101
) (
    input  logic               clk,
    input  logic               rst,
    conv_encoder_if.slave      bus
);
    localparam int CW = $clog2(lenout + 1);

    if (lenin != r * lenout) begin : g_bad_framing
        $error("conv_encoder: lenin must equal r*lenout");
    end

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t            state_q;
    logic [lenout-1:0] msg_q;
    logic [K-2:0]      s_q;
    logic [CW-1:0]     cnt_q;
    logic [r-1:0]      sym_q;
    logic [r-1:0]      sym_d;
    logic [lenin-1:0]  code_q;
    logic              valid_q;
    logic              done_q;
    logic              ready_q;
    logic              u;
    logic [K-1:0]      w;

    assign u = msg_q[lenout-1];
    assign w = {u, s_q};

    // c0 lands in the MSB of the symbol so codeout reads c0..c(r-1) left to right
    for (genvar j = 0; j < r; j++) begin : g_sym
        assign sym_d[r-1-j] = ^(w & G[(r-j)*K-1 -: K]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            sym_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            code_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            msg_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        msg_q   <= bus.msg_in;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        code_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= ENC;
                    end
                end
                ENC: begin
                    sym_q   <= sym_d;
                    valid_q <= 1'b1;
                    code_q  <= {code_q[lenin-r-1:0], sym_d};
                    s_q     <= (s_q >> 1) | ((K-1)'(u) << (K-2));
                    msg_q   <= msg_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= (cnt_q == CW'(lenout - 1)) ? DONE : ENC;
                end
                DONE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.sym_out   = sym_q;
    assign bus.sym_valid = valid_q;
    assign bus.codeout   = code_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed and random words against a scoreboard of expected symbols,
// code words and done latencies for conv_encoder.
module tb_conv_encoder;
    localparam int             r      = 2;
    localparam int             K      = 3;
    localparam int             lenin  = 10;
    localparam int             lenout = 5;
    localparam logic [r*K-1:0] G      = 6'b111101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_encoder_if #(.r(r), .lenin(lenin), .lenout(lenout)) bus ();

    conv_encoder #(.r(r), .K(K), .lenin(lenin), .lenout(lenout), .G(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy = 0;
    int prev_done = -1;
    bit hold_mode = 1'b0;
    bit acc_last = 1'b0;
    logic [r-1:0]     exp_sym[$];
    logic [lenin-1:0] exp_code[$];
    int               exp_acc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // History h[K-1] is the current bit, h[K-2] the most recent previous bit.
    task automatic push_word(input logic [lenout-1:0] m);
        logic [K-1:0]     h;
        logic [r-1:0]     sym;
        logic [lenin-1:0] code;
        h = '0;
        code = '0;
        for (int b = lenout - 1; b >= 0; b--) begin
            h = {m[b], h[K-1:1]};
            sym = '0;
            for (int j = 0; j < r; j++)
                for (int i = 0; i < K; i++)
                    sym[r-1-j] = sym[r-1-j] ^ (G[(r-j)*K-1-i] & h[K-1-i]);
            code = {code[lenin-r-1:0], sym};
            exp_sym.push_back(sym);
        end
        exp_code.push_back(code);
    endtask

    task automatic observe(input logic rr, input logic acc);
        chk("ready", {31'b0, bus.ready}, {31'b0, busy == 0});
        if (rr) begin
            chk("rst_sym_valid", {31'b0, bus.sym_valid}, 0);
            chk("rst_done", {31'b0, bus.done}, 0);
            chk("rst_codeout", 32'(bus.codeout), 0);
            chk("rst_sym_out", 32'(bus.sym_out), 0);
        end
        if (acc) chk("codeout_cleared", 32'(bus.codeout), 0);
        if (bus.sym_valid) begin
            chk("sym_expected", {31'b0, exp_sym.size() > 0}, 1);
            if (exp_sym.size() > 0) chk("sym", 32'(bus.sym_out), 32'(exp_sym.pop_front()));
        end
        if (bus.done) begin
            chk("done_expected", {31'b0, exp_code.size() > 0}, 1);
            chk("done_sym_valid", {31'b0, bus.sym_valid}, 0);
            chk("syms_left_at_done", exp_sym.size(), 0);
            if (exp_code.size() > 0) begin
                chk("codeout", 32'(bus.codeout), 32'(exp_code.pop_front()));
                chk("done_latency", cyc - exp_acc.pop_front(), lenout + 1);
            end
            if (hold_mode && prev_done >= 0) chk("done_cadence", cyc - prev_done, lenout + 2);
            prev_done = cyc;
        end
    endtask

    task automatic cycle();
        logic acc;
        logic rr;
        acc = bus.start && (busy == 0) && !rst;
        rr = rst;
        if (acc) begin
            push_word(bus.msg_in);
            exp_acc.push_back(cyc + 1);
        end
        @(posedge clk);
        cyc++;
        if (rr) begin
            busy = 0;
            exp_sym.delete();
            exp_code.delete();
            exp_acc.delete();
        end else if (acc) busy = lenout + 1;
        else if (busy > 0) busy--;
        acc_last = acc;
        #1;
        observe(rr, acc);
    endtask

    task automatic send(input logic [lenout-1:0] m);
        bus.msg_in = m;
        bus.start = 1'b1;
        acc_last = 1'b0;
        for (int i = 0; i < 20 && !acc_last; i++) cycle();
        chk("accept_timeout", {31'b0, acc_last}, 1);
        bus.start = 1'b0;
        bus.msg_in = ~m;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && exp_code.size() > 0; i++) cycle();
        chk("done_timeout", exp_code.size(), 0);
    endtask

    initial begin
        logic [lenout-1:0] words[4];
        int idx;
        words[0] = 5'b10101;
        words[1] = 5'b01010;
        words[2] = 5'b11100;
        words[3] = 5'b00111;
        bus.start = 1'b0;
        bus.msg_in = '0;
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        send(5'b10110);
        wait_done();
        chk("code_10110", 32'(bus.codeout), 32'(10'b1110000101));
        send(5'b00001);
        wait_done();
        chk("code_00001", 32'(bus.codeout), 32'(10'b0000000011));
        send(5'b00000);
        wait_done();
        chk("code_00000", 32'(bus.codeout), 0);
        repeat (2) cycle();
        chk("codeout_hold", 32'(bus.codeout), 0);

        hold_mode = 1'b1;
        prev_done = -1;
        idx = 0;
        bus.start = 1'b1;
        bus.msg_in = words[0];
        for (int i = 0; i < 60 && idx < 4; i++) begin
            cycle();
            if (acc_last) begin
                idx++;
                bus.msg_in = words[idx % 4];
            end
        end
        chk("hold_accepts", idx, 4);
        bus.start = 1'b0;
        wait_done();
        hold_mode = 1'b0;

        send(5'b11111);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (10) cycle();
        chk("abort_no_done_pending", exp_code.size(), 0);
        send(5'b10110);
        wait_done();
        chk("code_after_abort", 32'(bus.codeout), 32'(10'b1110000101));

        rst = 1'b1;
        bus.start = 1'b1;
        bus.msg_in = 5'b11011;
        cycle();
        rst = 1'b0;
        bus.start = 1'b0;
        cycle();
        chk("rst_beats_start", {31'b0, bus.sym_valid}, 0);

        for (int n = 0; n < 32; n++) begin
            send(lenout'($urandom));
            wait_done();
        end

        repeat (10) cycle();
        chk("final_syms_empty", exp_sym.size(), 0);
        chk("final_codes_empty", exp_code.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
